// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus for reg_file_sb: read, reserve and write requests plus
// registered read data, pending flags and the one-hot write strobe.
interface reg_file_sb_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    rn_1;
  logic [AW-1:0]    rn_2;
  logic [AW-1:0]    wn;
  logic             w;
  logic [WIDTH-1:0] wd;
  logic             rsv;
  logic [AW-1:0]    rsv_n;
  logic [WIDTH-1:0] rd_1;
  logic [WIDTH-1:0] rd_2;
  logic             busy_1;
  logic             busy_2;
  logic [DEPTH-1:0] store;

  modport master (
    output rn_1, rn_2, wn, w, wd, rsv, rsv_n,
    input  rd_1, rd_2, busy_1, busy_2, store
  );

  modport slave (
    input  rn_1, rn_2, wn, w, wd, rsv, rsv_n,
    output rd_1, rd_2, busy_1, busy_2, store
  );
endinterface

// File: rtl/reg_file_sb.sv
// DEPTH x WIDTH register file, two registered read ports, one write port and a
// per-register pending scoreboard. Define REG_BYPASS_EN for write-first reads.
module reg_file_sb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            sb_q, sb_d;
  logic [WIDTH-1:0]            rd_1_q, rd_1_d;
  logic [WIDTH-1:0]            rd_2_q, rd_2_d;
  logic                        busy_1_q, busy_1_d;
  logic                        busy_2_q, busy_2_d;
  logic [DEPTH-1:0]            store_c;

  // Reserve is applied after the write clear so a same-address reserve wins.
  always_comb begin
    mem_d = mem_q;
    sb_d  = sb_q;
    if (bus.w) begin
      mem_d[bus.wn] = bus.wd;
      sb_d[bus.wn]  = 1'b0;
    end
    if (bus.rsv) begin
      sb_d[bus.rsv_n] = 1'b1;
    end
  end

  always_comb begin
`ifdef REG_BYPASS_EN
    rd_1_d   = (bus.w && (bus.wn == bus.rn_1)) ? bus.wd : mem_q[bus.rn_1];
    rd_2_d   = (bus.w && (bus.wn == bus.rn_2)) ? bus.wd : mem_q[bus.rn_2];
    busy_1_d = sb_d[bus.rn_1];
    busy_2_d = sb_d[bus.rn_2];
`else
    rd_1_d   = mem_q[bus.rn_1];
    rd_2_d   = mem_q[bus.rn_2];
    busy_1_d = sb_q[bus.rn_1];
    busy_2_d = sb_q[bus.rn_2];
`endif
  end

  always_comb begin
    store_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      store_c[i] = bus.w && (bus.wn == AW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '0;
      sb_q     <= '0;
      rd_1_q   <= '0;
      rd_2_q   <= '0;
      busy_1_q <= 1'b0;
      busy_2_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      sb_q     <= sb_d;
      rd_1_q   <= rd_1_d;
      rd_2_q   <= rd_2_d;
      busy_1_q <= busy_1_d;
      busy_2_q <= busy_2_d;
    end
  end

  assign bus.rd_1   = rd_1_q;
  assign bus.rd_2   = rd_2_q;
  assign bus.busy_1 = busy_1_q;
  assign bus.busy_2 = busy_2_q;
  assign bus.store  = store_c;
endmodule
